// File: rtl/nn_load_ctrl.sv
// Serial loader: streams binary weights (4 layers) then an input vector into memories, then hands
// off to the compute stage. Define NN_LOAD_PARITY_EN to add a checked parity beat per segment.
module nn_load_ctrl #(
  parameter int unsigned W_ADDR_LEN = 20,
  parameter int unsigned X_ADDR_LEN = 10,
  parameter int unsigned W_DEPTH    = 8,
  parameter int unsigned X_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_go,
  input  logic                  in_valid,
  input  logic                  in_data,
  output logic                  in_ready,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic                  w_data,
  output logic [1:0]            w_sel,
  output logic [1:0]            w_rw,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic                  x_data,
  output logic [1:0]            x_sel,
  output logic [1:0]            x_rw,
  output logic                  start_compute,
  input  logic                  compute_done,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err
);

`ifdef NN_LOAD_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam logic [W_ADDR_LEN-1:0] WLast = W_ADDR_LEN'(W_DEPTH - 1);
  localparam logic [X_ADDR_LEN-1:0] XLast = X_ADDR_LEN'(X_DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadX,
    StStart,
    StWaitDone
  } state_e;

  state_e                  state;
  logic [W_ADDR_LEN-1:0]   w_cnt;
  logic [X_ADDR_LEN-1:0]   x_cnt;
  logic [1:0]              layer;
  logic                    par_phase;
  logic                    par_acc;
  logic                    err_q;
  logic                    accept;

  assign in_ready = (state == StLoadW) || (state == StLoadX);
  assign busy     = (state != StIdle);
  assign accept   = in_valid && in_ready;
  assign x_sel    = 2'b00;
  assign err      = ParityEn ? err_q : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      w_cnt         <= '0;
      x_cnt         <= '0;
      layer         <= 2'd0;
      par_phase     <= 1'b0;
      par_acc       <= 1'b0;
      err_q         <= 1'b0;
      w_addr        <= '0;
      w_data        <= 1'b0;
      w_sel         <= 2'd0;
      w_rw          <= 2'b00;
      x_addr        <= '0;
      x_data        <= 1'b0;
      x_rw          <= 2'b00;
      start_compute <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      // Command and pulse outputs default low; each is raised for exactly one cycle below.
      w_rw          <= 2'b00;
      x_rw          <= 2'b00;
      start_compute <= 1'b0;
      load_done     <= 1'b0;

      unique case (state)
        StIdle: begin
          if (load_go) begin
            state     <= StLoadW;
            w_cnt     <= '0;
            x_cnt     <= '0;
            layer     <= 2'd0;
            par_phase <= 1'b0;
            par_acc   <= 1'b0;
            err_q     <= 1'b0;
          end
        end

        StLoadW: begin
          if (accept) begin
            if (par_phase) begin
              par_phase <= 1'b0;
              par_acc   <= 1'b0;
              if (in_data != par_acc) begin
                err_q <= 1'b1;
                state <= StIdle;
              end else if (layer == 2'd3) begin
                state <= StLoadX;
              end else begin
                layer <= layer + 2'd1;
              end
            end else begin
              w_rw    <= 2'b01;
              w_addr  <= w_cnt;
              w_data  <= in_data;
              w_sel   <= layer;
              par_acc <= par_acc ^ in_data;
              if (w_cnt == WLast) begin
                w_cnt <= '0;
                if (ParityEn) begin
                  par_phase <= 1'b1;
                end else if (layer == 2'd3) begin
                  state <= StLoadX;
                end else begin
                  layer <= layer + 2'd1;
                end
              end else begin
                w_cnt <= w_cnt + 1'b1;
              end
            end
          end
        end

        StLoadX: begin
          if (accept) begin
            if (par_phase) begin
              par_phase <= 1'b0;
              par_acc   <= 1'b0;
              if (in_data != par_acc) begin
                err_q <= 1'b1;
                state <= StIdle;
              end else begin
                state <= StStart;
              end
            end else begin
              x_rw    <= 2'b01;
              x_addr  <= x_cnt;
              x_data  <= in_data;
              par_acc <= par_acc ^ in_data;
              if (x_cnt == XLast) begin
                x_cnt <= '0;
                if (ParityEn) begin
                  par_phase <= 1'b1;
                end else begin
                  state <= StStart;
                end
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
        end

        StStart: begin
          start_compute <= 1'b1;
          state         <= StWaitDone;
        end

        StWaitDone: begin
          if (compute_done) begin
            load_done <= 1'b1;
            state     <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_load_ctrl.sv
// Randomised scoreboard bench for nn_load_ctrl: a driver pushes expected writes/pulses derived from
// beat indices, a negedge monitor pops and compares whatever the DUT emits.
module tb_nn_load_ctrl;
  localparam int WA = 20;
  localparam int XA = 10;
  localparam int WD = 8;
  localparam int XD = 8;
`ifdef NN_LOAD_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int KW = 0, KX = 1, KS = 2, KD = 3;

  logic          clk, rst, load_go, in_valid, in_data, in_ready;
  logic [WA-1:0] w_addr;
  logic          w_data;
  logic [1:0]    w_sel, w_rw;
  logic [XA-1:0] x_addr;
  logic          x_data;
  logic [1:0]    x_sel, x_rw;
  logic          start_compute, compute_done, busy, load_done, err;

  nn_load_ctrl #(
    .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .W_DEPTH(WD), .X_DEPTH(XD)
  ) dut (
    .clk(clk), .rst(rst), .load_go(load_go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data), .w_sel(w_sel), .w_rw(w_rw),
    .x_addr(x_addr), .x_data(x_data), .x_sel(x_sel), .x_rw(x_rw),
    .start_compute(start_compute), .compute_done(compute_done), .busy(busy),
    .load_done(load_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int kind;
    int sel;
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_x_cyc = -10;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic void push(input int kind, input int sel, input int addr, input int data);
    exp_t e;
    e.kind = kind; e.sel = sel; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Reference: beat n of a load maps to a weight/input slot purely from segment geometry.
  function automatic void model_beat(input int n, input bit d);
    int seg_w = WD + PAR;
    int k;
    if (n < 4 * seg_w) begin
      if ((n % seg_w) < WD) push(KW, n / seg_w, n % seg_w, int'(d));
    end else begin
      k = n - 4 * seg_w;
      if (k < XD) push(KX, 0, k, int'(d));
    end
  endfunction

  task automatic mon_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%0d want=none (t=%0t)", kind, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == KW) begin
      chk("w_rw", w_rw, 1);
      chk("w_sel", w_sel, e.sel);
      chk("w_addr", w_addr, e.addr);
      chk("w_data", w_data, e.data);
    end else if (kind == KX) begin
      chk("x_rw", x_rw, 1);
      chk("x_sel", x_sel, 0);
      chk("x_addr", x_addr, e.addr);
      chk("x_data", x_data, e.data);
      last_x_cyc = cyc;
    end else if (kind == KS) begin
      chk("start_latency", cyc, last_x_cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (w_rw != 2'b00) mon_event(KW);
      if (x_rw != 2'b00) mon_event(KX);
      if (start_compute) mon_event(KS);
      if (load_done) mon_event(KD);
    end
  end

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // mode 0: continuous, data alternates; 1: valid every other cycle; 2: random valid/data plus
  // stray load_go/compute_done pulses. corrupt >= 0 flips that segment's parity beat.
  task automatic run_load(input int mode, input int abort_at, input int corrupt);
    bit bq[$];
    bit acc, b;
    int di = 0, n = 0, c = 0, stop_at, len;
    for (int s = 0; s < 5; s++) begin
      acc = 1'b0;
      len = (s < 4) ? WD : XD;
      for (int j = 0; j < len; j++) begin
        b = (mode == 2) ? 1'($urandom) : 1'(di % 2);
        di++;
        acc ^= b;
        bq.push_back(b);
      end
      if (PAR != 0) bq.push_back((s == corrupt) ? ~acc : acc);
    end
    stop_at = bq.size();
    if (abort_at > 0) stop_at = abort_at;
    if (corrupt >= 0) stop_at = (corrupt < 4) ? (corrupt + 1) * (WD + PAR) : bq.size();

    load_go = 1'b1;
    @(posedge clk); #1;
    load_go = 1'b0;
    chk("busy_load", busy, 1);
    chk("err_cleared", err, 0);
    while (n < stop_at && c < 2000) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2 == 0) : 1'($urandom_range(0, 2) != 0);
      in_data  = bq[n];
      if (mode == 2) begin
        load_go      = ($urandom_range(0, 7) == 0);
        compute_done = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_beat(n, bq[n]);
        n++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    load_go = 1'b0;
    compute_done = 1'b0;
    chk("load_beats_accepted", n, stop_at);
    if (n == bq.size() && corrupt < 0) push(KS, 0, 0, 0);
  endtask

  task automatic finish_compute();
    wait_empty(100, "start_seen");
    @(posedge clk); #1;
    compute_done = 1'b1;
    push(KD, 0, 0, 0);
    @(posedge clk); #1;
    compute_done = 1'b0;
    wait_empty(10, "done_seen");
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("w_sel_hold", w_sel, 3);
  endtask

  initial begin
    rst = 1'b0; load_go = 1'b0; in_valid = 1'b0; in_data = 1'b0; compute_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_rw", w_rw, 0);
    chk("rst_x_rw", x_rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_start", start_compute, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_load(0, 0, -1);
    finish_compute();
    run_load(1, 0, -1);
    finish_compute();

    // Beats offered while idle must not be taken.
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("in_ready_idle", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_load(2, 0, -1);
      finish_compute();
    end

    // Abort after beat 13: reset acts immediately, without a clock edge.
    run_load(0, 13, -1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_w_rw", w_rw, 0);
    chk("abort_w_addr", w_addr, 0);
    chk("abort_w_sel", w_sel, 0);
    chk("abort_w_data", w_data, 0);
    chk("abort_x_rw", x_rw, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_load(0, 0, -1);
    finish_compute();

`ifdef NN_LOAD_PARITY_EN
    run_load(2, 0, 2);
    @(negedge clk);
    chk("parity_err", err, 1);
    chk("parity_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("parity_err_sticky", err, 1);
    @(posedge clk); #1;
    run_load(0, 0, -1);
    finish_compute();
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
